// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - shared state codes, opcodes and select encodings for the multi-cycle control FSM
package mc_ctrl_pkg;

  localparam logic [3:0] S_FETCH     = 4'd0;
  localparam logic [3:0] S_DECODE    = 4'd1;
  localparam logic [3:0] S_MEM_ADR   = 4'd2;
  localparam logic [3:0] S_MEM_READ  = 4'd3;
  localparam logic [3:0] S_MEM_WB    = 4'd4;
  localparam logic [3:0] S_MEM_WRITE = 4'd5;
  localparam logic [3:0] S_EXEC_R    = 4'd6;
  localparam logic [3:0] S_EXEC_I    = 4'd7;
  localparam logic [3:0] S_ALU_WB    = 4'd8;
  localparam logic [3:0] S_BRANCH    = 4'd9;
  localparam logic [3:0] S_JAL       = 4'd10;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    IMM_I = 2'b00,
    IMM_S = 2'b01,
    IMM_B = 2'b10,
    IMM_J = 2'b11
  } imm_src_e;

  typedef enum logic [1:0] {
    RES_ALU_OUT    = 2'b00,
    RES_MEM_DATA   = 2'b01,
    RES_ALU_DIRECT = 2'b10
  } result_src_e;

  typedef enum logic [1:0] {
    SRC_A_PC     = 2'b00,
    SRC_A_OLD_PC = 2'b01,
    SRC_A_RD1    = 2'b10
  } src_a_e;

  typedef enum logic [1:0] {
    SRC_B_RD2  = 2'b00,
    SRC_B_IMM  = 2'b01,
    SRC_B_FOUR = 2'b10
  } src_b_e;

  function automatic logic is_mem_state(input logic [3:0] st);
    return (st == S_FETCH) || (st == S_MEM_READ) || (st == S_MEM_WRITE);
  endfunction

endpackage

// File: rtl/mc_control_fsm_if.sv
// rtl/mc_control_fsm_if.sv - unified memory port handshake between control FSM and memory
interface mc_control_fsm_if;
  logic mem_req;
  logic mem_wr_en;
  logic adr_src;
  logic mem_ready;

  modport master (output mem_req, output mem_wr_en, output adr_src, input mem_ready);
  modport slave  (input mem_req, input mem_wr_en, input adr_src, output mem_ready);
endinterface

// File: rtl/mc_control_fsm_alu_decoder.sv
// rtl/mc_control_fsm_alu_decoder.sv - state/funct3/funct7_5 to alu_control decode
module mc_alu_decoder
  import mc_ctrl_pkg::*;
(
  input  logic [3:0] state,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output logic [2:0] alu_control
);

  logic [2:0] f3_op;

  // funct7_5 selects sub only for register-register ops; there is no subi
  always_comb begin
    f3_op = ALU_ADD;
    case (funct3)
      3'b000:  f3_op = (funct7_5 && (state == S_EXEC_R)) ? ALU_SUB : ALU_ADD;
      3'b010:  f3_op = ALU_SLT;
      3'b110:  f3_op = ALU_OR;
      3'b111:  f3_op = ALU_AND;
      default: f3_op = ALU_ADD;
    endcase
  end

  always_comb begin
    alu_control = ALU_ADD;
    case (state)
      S_EXEC_R, S_EXEC_I: alu_control = f3_op;
      S_BRANCH:           alu_control = ALU_SUB;
      default:            alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// rtl/mc_control_fsm.sv - multi-cycle RV32I control sequencer with memory-wait watchdog
module mc_control_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int WAIT_CNT_WIDTH = 8,
  parameter int MAX_WAIT       = 255
) (
  input  logic                    clk,
  input  logic                    rst_n,
  mc_control_fsm_if.master        mem_bus,
  input  logic [6:0]              opcode,
  input  logic [2:0]              funct3,
  input  logic                    funct7_5,
  input  logic                    zero,
  output logic                    ir_wr_en,
  output logic                    pc_wr_en,
  output logic                    reg_wr_en,
  output logic [1:0]              alu_src_a,
  output logic [1:0]              alu_src_b,
  output logic [2:0]              alu_control,
  output logic [1:0]              result_src,
  output logic [1:0]              imm_src,
  output logic                    illegal_instr,
  output logic                    mem_err,
  output logic                    instr_done,
  output logic [3:0]              state_o
);

  logic [3:0]                state_q;
  logic [3:0]                state_d;
  logic [WAIT_CNT_WIDTH-1:0] wait_cnt_q;
  logic                      abort_q;
  logic                      mem_active;
  logic                      ready;
  logic                      timeout;
  logic                      illegal_c;
  logic                      req_c;
  logic                      wr_c;
  logic                      adr_c;
  logic                      ir_c;
  logic                      pc_c;
  logic                      reg_c;
  logic                      done_c;

  // abort_q marks the cycle after a watchdog expiry: the request is withdrawn for one cycle
  assign mem_active = is_mem_state(state_q) && !abort_q;
  assign ready      = mem_active && mem_bus.mem_ready;
  assign timeout    = mem_active && !mem_bus.mem_ready &&
                      (wait_cnt_q == WAIT_CNT_WIDTH'(MAX_WAIT));

  always_comb begin
    state_d   = state_q;
    illegal_c = 1'b0;
    case (state_q)
      S_FETCH:     if (ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEM_ADR;
          OP_R:              state_d = S_EXEC_R;
          OP_I:              state_d = S_EXEC_I;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          default: begin
            state_d   = S_FETCH;
            illegal_c = 1'b1;
          end
        endcase
      end
      S_MEM_ADR:   state_d = (opcode == OP_STORE) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  if (ready) state_d = S_MEM_WB;
      S_MEM_WB:    state_d = S_FETCH;
      S_MEM_WRITE: if (ready) state_d = S_FETCH;
      S_EXEC_R:    state_d = S_ALU_WB;
      S_EXEC_I:    state_d = S_ALU_WB;
      S_ALU_WB:    state_d = S_FETCH;
      S_BRANCH:    state_d = S_FETCH;
      S_JAL:       state_d = S_ALU_WB;
      default:     state_d = S_FETCH;
    endcase
    if (timeout) state_d = S_FETCH;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_FETCH;
      wait_cnt_q <= '0;
      abort_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      abort_q <= timeout;
      if (timeout || (state_d != state_q) || !mem_active)
        wait_cnt_q <= '0;
      else if (!mem_bus.mem_ready)
        wait_cnt_q <= wait_cnt_q + 1'b1;
    end
  end

  always_comb begin
    req_c      = 1'b0;
    wr_c       = 1'b0;
    adr_c      = 1'b0;
    ir_c       = 1'b0;
    pc_c       = 1'b0;
    reg_c      = 1'b0;
    done_c     = 1'b0;
    alu_src_a  = SRC_A_PC;
    alu_src_b  = SRC_B_RD2;
    result_src = RES_ALU_OUT;
    imm_src    = IMM_I;
    case (state_q)
      S_FETCH: begin
        req_c      = !abort_q;
        alu_src_b  = SRC_B_FOUR;
        result_src = RES_ALU_DIRECT;
        ir_c       = ready;
        pc_c       = ready;
      end
      S_DECODE: begin
        alu_src_a = SRC_A_OLD_PC;
        alu_src_b = SRC_B_IMM;
        imm_src   = IMM_B;
      end
      S_MEM_ADR: begin
        alu_src_a = SRC_A_RD1;
        alu_src_b = SRC_B_IMM;
        imm_src   = (opcode == OP_STORE) ? IMM_S : IMM_I;
      end
      S_MEM_READ: begin
        req_c = 1'b1;
        adr_c = 1'b1;
      end
      S_MEM_WB: begin
        result_src = RES_MEM_DATA;
        reg_c      = 1'b1;
        done_c     = 1'b1;
      end
      S_MEM_WRITE: begin
        req_c  = 1'b1;
        wr_c   = 1'b1;
        adr_c  = 1'b1;
        done_c = ready;
      end
      S_EXEC_R: begin
        alu_src_a = SRC_A_RD1;
        alu_src_b = SRC_B_RD2;
      end
      S_EXEC_I: begin
        alu_src_a = SRC_A_RD1;
        alu_src_b = SRC_B_IMM;
        imm_src   = IMM_I;
      end
      S_ALU_WB: begin
        reg_c  = 1'b1;
        done_c = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = SRC_A_RD1;
        alu_src_b = SRC_B_RD2;
        pc_c      = zero ^ funct3[0];
        done_c    = 1'b1;
      end
      S_JAL: begin
        alu_src_a = SRC_A_OLD_PC;
        alu_src_b = SRC_B_FOUR;
        pc_c      = 1'b1;
      end
      default: begin
        req_c = 1'b0;
      end
    endcase
  end

  mc_alu_decoder u_alu_decoder (
    .state       (state_q),
    .funct3      (funct3),
    .funct7_5    (funct7_5),
    .alu_control (alu_control)
  );

  // Strobes are gated by rst_n so nothing is written while reset is held
  assign mem_bus.mem_req   = rst_n & req_c;
  assign mem_bus.mem_wr_en = rst_n & wr_c;
  assign mem_bus.adr_src   = adr_c;
  assign ir_wr_en          = rst_n & ir_c;
  assign pc_wr_en          = rst_n & pc_c;
  assign reg_wr_en         = rst_n & reg_c;
  assign illegal_instr     = rst_n & illegal_c;
  assign mem_err           = rst_n & timeout;
  assign instr_done        = rst_n & done_c;
  assign state_o           = state_q;

endmodule
